seq_restoring_divider: RTL and testbench

//  Iterative unsigned restoring divider: the inverse of the array multiplier built from registered S-cells.

---
 rtl/seq_restoring_divider_pkg.sv | 16 +
 rtl/seq_restoring_divider_div_step.sv | 29 ++
 rtl/seq_restoring_divider.sv | 106 ++++++++++
 tb/tb_seq_restoring_divider.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding
// and the sizing rule for the step counter.
package seq_restoring_divider_pkg;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_CALC = 2'd1,
      DIV_FIN  = 2'd2
   } div_state_t;

   // The counter must hold WIDTH-1, so clog2(WIDTH) bits suffice (at least one bit).
   function automatic int count_width(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/seq_restoring_divider_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial
// subtract the divisor, keep the difference only when it is non-negative.
module div_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             bit_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   always_comb begin
      shifted = {rem_in, bit_in};
      trial   = shifted - {1'b0, divisor};
      // A set MSB means the subtraction borrowed; shifted is then < divisor and fits in WIDTH bits.
      if (trial[WIDTH]) begin
         rem_out = shifted[WIDTH-1:0];
         q_bit   = 1'b0;
      end else begin
         rem_out = trial[WIDTH-1:0];
         q_bit   = 1'b1;
      end
   end

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider producing one quotient bit per clock,
// with a start/busy/done handshake and a divide-by-zero flag.
module seq_restoring_divider
   import seq_restoring_divider_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CNT_W = count_width(WIDTH);
   localparam logic [CNT_W-1:0] COUNT_INIT = CNT_W'(WIDTH - 1);

   div_state_t       state;
   div_state_t       state_next;
   logic [WIDTH-1:0] rem_acc;
   logic [WIDTH-1:0] q_acc;
   logic [WIDTH-1:0] divisor_r;
   logic [CNT_W-1:0] count;
   logic             dbz_r;
   logic [WIDTH-1:0] step_rem;
   logic             step_q;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem_acc),
      .bit_in  (q_acc[WIDTH-1]),
      .divisor (divisor_r),
      .rem_out (step_rem),
      .q_bit   (step_q)
   );

   always_ff @(posedge clk) begin
      if (!rst) state <= DIV_IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         DIV_IDLE: if (start) state_next = (divisor == '0) ? DIV_FIN : DIV_CALC;
         DIV_CALC: if (count == '0) state_next = DIV_FIN;
         DIV_FIN:  state_next = DIV_IDLE;
         default:  state_next = DIV_IDLE;
      endcase
   end

   always_comb begin
      busy = (state != DIV_IDLE);
   end

   // Datapath: q_acc starts as the dividend and is shifted out MSB-first while
   // quotient bits shift in at the LSB, so it ends holding the quotient.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rem_acc     <= '0;
         q_acc       <= '0;
         divisor_r   <= '0;
         count       <= '0;
         dbz_r       <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            DIV_IDLE: begin
               if (start) begin
                  divisor_r <= divisor;
                  q_acc     <= dividend;
                  rem_acc   <= '0;
                  count     <= COUNT_INIT;
                  dbz_r     <= (divisor == '0);
               end
            end
            DIV_CALC: begin
               rem_acc <= step_rem;
               q_acc   <= {q_acc[WIDTH-2:0], step_q};
               if (count != '0) count <= count - 1'b1;
            end
            DIV_FIN: begin
               done        <= 1'b1;
               div_by_zero <= dbz_r;
               if (dbz_r) begin
                  quotient  <= '1;
                  remainder <= q_acc;
               end else begin
                  quotient  <= q_acc;
                  remainder <= rem_acc;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (WIDTH=8): directed scenarios
// plus randomized operands checked against plain / and % arithmetic.
module tb_seq_restoring_divider;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int n_cmp = 0;
   int n_bad = 0;

   seq_restoring_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

   // Called #1 after the accepting edge; returns edges until done (-1 on timeout).
   task automatic wait_done(output int lat, output int bcnt);
      lat  = -1;
      bcnt = 0;
      for (int n = 1; n <= 40; n++) begin
         if (busy) bcnt++;
         @(posedge clk); #1;
         if (done) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int bcnt);
      start = 1'b1; dividend = a; divisor = b;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(lat, bcnt);
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
      n_cmp++; if (quotient !== 8'd0) begin n_bad++; $display("FAIL reset_q: got %0d want 0", quotient); end
      n_cmp++; if (remainder !== 8'd0) begin n_bad++; $display("FAIL reset_r: got %0d want 0", remainder); end
      n_cmp++; if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int lat, bcnt;
      run_op(8'd100, 8'd7, lat, bcnt);
      n_cmp++; if (lat != W + 1) begin n_bad++; $display("FAIL basic_lat: got %0d want %0d", lat, W + 1); end
      n_cmp++; if (bcnt != W + 1) begin n_bad++; $display("FAIL basic_busy_cycles: got %0d want %0d", bcnt, W + 1); end
      n_cmp++; if (quotient !== 8'd14) begin n_bad++; $display("FAIL basic_q: got %0d want 14", quotient); end
      n_cmp++; if (remainder !== 8'd2) begin n_bad++; $display("FAIL basic_r: got %0d want 2", remainder); end
      n_cmp++; if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL basic_dbz: got %b want 0", div_by_zero); end
      @(posedge clk); #1;
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL done_pulse: got %b want 0", done); end
      n_cmp++; if (quotient !== 8'd14) begin n_bad++; $display("FAIL hold_q: got %0d want 14", quotient); end

      run_op(8'd5, 8'd9, lat, bcnt);
      n_cmp++; if (lat != W + 1) begin n_bad++; $display("FAIL small_lat: got %0d want %0d", lat, W + 1); end
      n_cmp++; if (quotient !== 8'd0 || remainder !== 8'd5)
         begin n_bad++; $display("FAIL small_qr: got %0d/%0d want 0/5", quotient, remainder); end

      run_op(8'd255, 8'd1, lat, bcnt);
      n_cmp++; if (lat != W + 1) begin n_bad++; $display("FAIL div1_lat: got %0d want %0d", lat, W + 1); end
      n_cmp++; if (quotient !== 8'd255 || remainder !== 8'd0)
         begin n_bad++; $display("FAIL div1_qr: got %0d/%0d want 255/0", quotient, remainder); end
   endtask

   task automatic test_div_zero();
      int lat, bcnt;
      start = 1'b1; dividend = 8'd37; divisor = 8'd0;
      @(posedge clk); #1;
      start = 1'b0;
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL dbz_busy: got %b want 1", busy); end
      wait_done(lat, bcnt);
      n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL dbz_lat: got %0d want 1", lat); end
      n_cmp++; if (quotient !== 8'hFF || remainder !== 8'd37 || div_by_zero !== 1'b1)
         begin n_bad++; $display("FAIL dbz_result: got %0d/%0d/%b want 255/37/1", quotient, remainder, div_by_zero); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL dbz_idle: got busy %b want 0", busy); end
   endtask

   task automatic test_busy_ignore();
      int lat;
      start = 1'b1; dividend = 8'd200; divisor = 8'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1; dividend = 8'd9; divisor = 8'd2;
      @(posedge clk); #1;
      start = 1'b0;
      lat = -1;
      for (int n = 5; n <= 40; n++) begin
         @(posedge clk); #1;
         if (done) begin lat = n; break; end
      end
      n_cmp++; if (lat != W + 1) begin n_bad++; $display("FAIL ignore_lat: got %0d want %0d", lat, W + 1); end
      n_cmp++; if (quotient !== 8'd66 || remainder !== 8'd2)
         begin n_bad++; $display("FAIL ignore_qr: got %0d/%0d want 66/2", quotient, remainder); end
      @(posedge clk); #1;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ignore_no_restart: got busy %b want 0", busy); end
   endtask

   task automatic test_reset_mid();
      int lat, bcnt, ndone;
      start = 1'b1; dividend = 8'd200; divisor = 8'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      n_cmp++; if (busy !== 1'b0 || done !== 1'b0)
         begin n_bad++; $display("FAIL midrst_ctrl: got busy %b done %b want 0 0", busy, done); end
      n_cmp++; if (quotient !== 8'd0 || remainder !== 8'd0 || div_by_zero !== 1'b0)
         begin n_bad++; $display("FAIL midrst_out: got %0d/%0d/%b want 0/0/0", quotient, remainder, div_by_zero); end
      ndone = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      n_cmp++; if (ndone != 0) begin n_bad++; $display("FAIL midrst_no_done: got %0d pulses want 0", ndone); end
      run_op(8'd50, 8'd5, lat, bcnt);
      n_cmp++; if (lat != W + 1 || quotient !== 8'd10 || remainder !== 8'd0)
         begin n_bad++; $display("FAIL midrst_next: got lat %0d %0d/%0d want %0d 10/0", lat, quotient, remainder, W + 1); end
   endtask

   task automatic test_back_to_back();
      int lat, bcnt;
      run_op(8'd81, 8'd4, lat, bcnt);
      n_cmp++; if (lat != W + 1 || quotient !== 8'd20 || remainder !== 8'd1)
         begin n_bad++; $display("FAIL b2b_first: got lat %0d %0d/%0d want %0d 20/1", lat, quotient, remainder, W + 1); end
      start = 1'b1; dividend = 8'd17; divisor = 8'd5;
      @(posedge clk); #1;
      start = 1'b0;
      n_cmp++; if (busy !== 1'b1 || done !== 1'b0)
         begin n_bad++; $display("FAIL b2b_accept: got busy %b done %b want 1 0", busy, done); end
      n_cmp++; if (quotient !== 8'd20 || remainder !== 8'd1)
         begin n_bad++; $display("FAIL b2b_hold: got %0d/%0d want 20/1", quotient, remainder); end
      wait_done(lat, bcnt);
      n_cmp++; if (lat != W + 1 || quotient !== 8'd3 || remainder !== 8'd2)
         begin n_bad++; $display("FAIL b2b_second: got lat %0d %0d/%0d want %0d 3/2", lat, quotient, remainder, W + 1); end
   endtask

   task automatic test_random();
      int lat, bcnt, exp_lat;
      logic [W-1:0] a, b, eq, er;
      logic         ed;
      for (int i = 0; i < 3000; i++) begin
         a = W'($urandom_range(0, 255));
         b = ($urandom_range(0, 15) == 0) ? 8'd0 : W'($urandom_range(0, 255));
         if (b == 0) begin
            eq = 8'hFF; er = a; ed = 1'b1; exp_lat = 1;
         end else begin
            eq = a / b; er = a % b; ed = 1'b0; exp_lat = W + 1;
         end
         run_op(a, b, lat, bcnt);
         n_cmp++;
         if (lat != exp_lat || quotient !== eq || remainder !== er || div_by_zero !== ed) begin
            n_bad++;
            $display("FAIL random %0d/%0d: got lat %0d q %0d r %0d dbz %b want lat %0d q %0d r %0d dbz %b",
                     a, b, lat, quotient, remainder, div_by_zero, exp_lat, eq, er, ed);
         end
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_div_zero();
      test_busy_ignore();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
